// File: rtl/sma_v2_pkg.sv
// Shared types and helpers for the sma_v2 moving-average filter.
package sma_v2_pkg;

  typedef enum logic [1:0] {
    ST_RESTART = 2'd0,
    ST_FILL    = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Window select saturates at the largest window the RAM can hold.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_k);
    return (sel > max_k) ? max_k : sel;
  endfunction

endpackage

// File: rtl/sma_v2_ram.sv
// Simple dual-port history RAM: one write port, one registered read port.
module sma_v2_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      o_rdata <= mem_r[i_raddr];
    end
  end

endmodule

// File: rtl/sma_v2.sv
// Moving average over a runtime-selectable 2^k window, history held in sma_v2_ram.
// Build option SMA_V2_ROUND_EN: round half up instead of flooring the final shift.
module sma_v2
  import sma_v2_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LOG2_MAX = 15,
  parameter int SEL_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]  i_window_sel,
  input  logic              i_clear,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);
  localparam int SUM_W = DATA_W + LOG2_MAX;
  localparam int CNT_W = LOG2_MAX + 1;
  localparam logic [CNT_W-1:0]    CNT_ONE = {{LOG2_MAX{1'b0}}, 1'b1};
  localparam logic [LOG2_MAX-1:0] PTR_ONE = {{(LOG2_MAX-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]    K_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};

  state_e                  state_r;
  logic [SEL_W-1:0]        sel_r;
  logic [SEL_W-1:0]        k_r;
  logic [LOG2_MAX-1:0]     ptr_r;
  logic [CNT_W-1:0]        fill_r;
  logic signed [SUM_W-1:0] sum_r;
  logic                    s0_valid_r;
  logic                    s0_full_r;
  logic                    s0_emit_r;
  logic [DATA_W-1:0]       s0_data_r;
  logic [LOG2_MAX-1:0]     s0_ptr_r;
  logic                    s1_emit_r;
  logic                    o_valid_r;
  logic                    o_full_r;
  logic [DATA_W-1:0]       o_data_r;

  logic [DATA_W-1:0]       rd_data_s;
  logic [CNT_W-1:0]        n_s;
  logic [CNT_W-1:0]        n_m1_s;
  logic [CNT_W-1:0]        eff_s;
  logic [CNT_W-1:0]        fill_inc_s;
  logic [LOG2_MAX-1:0]     ptr_next_s;
  logic                    restart_req_s;
  logic                    accept_s;
  logic signed [SUM_W-1:0] data_ext_s;
  logic signed [SUM_W-1:0] oldest_s;
  logic signed [SUM_W-1:0] sum_next_s;
  logic signed [SUM_W:0]   rnd_s;
  logic signed [SUM_W:0]   rounded_s;
  logic signed [SUM_W:0]   shifted_s;
  logic                    unused_s;

  assign restart_req_s = i_clear || ((state_r != ST_RESTART) && (sel_r != k_r));
  assign accept_s      = i_valid && (state_r != ST_RESTART) && !restart_req_s;

  assign n_s        = CNT_ONE << k_r;
  assign n_m1_s     = n_s - CNT_ONE;
  assign ptr_next_s = (ptr_r + PTR_ONE) & n_m1_s[LOG2_MAX-1:0];
  // Fullness at accept must count the sample still sitting in stage 0.
  assign eff_s      = fill_r + {{LOG2_MAX{1'b0}}, s0_valid_r};
  assign fill_inc_s = (fill_r == n_s) ? fill_r : (fill_r + CNT_ONE);
  assign data_ext_s = {{LOG2_MAX{s0_data_r[DATA_W-1]}}, s0_data_r};

  // Sample leaving the window; k=0 replaces the whole sum so the RAM is bypassed.
  always_comb begin
    oldest_s = {SUM_W{1'b0}};
    if (k_r == {SEL_W{1'b0}}) begin
      oldest_s = sum_r;
    end else if (s0_full_r) begin
      oldest_s = {{LOG2_MAX{rd_data_s[DATA_W-1]}}, rd_data_s};
    end else begin
      oldest_s = {SUM_W{1'b0}};
    end
  end

  assign sum_next_s = sum_r + data_ext_s - oldest_s;

`ifdef SMA_V2_ROUND_EN
  // Half an LSB of the shifted result, for round half up.
  always_comb begin
    rnd_s = {(SUM_W+1){1'b0}};
    if (k_r != {SEL_W{1'b0}}) begin
      rnd_s = {{SUM_W{1'b0}}, 1'b1} << (k_r - K_ONE);
    end else begin
      rnd_s = {(SUM_W+1){1'b0}};
    end
  end
`else
  assign rnd_s = {(SUM_W+1){1'b0}};
`endif

  assign rounded_s = {sum_r[SUM_W-1], sum_r} + rnd_s;
  assign shifted_s = rounded_s >>> k_r;
  assign unused_s  = ^shifted_s[SUM_W:DATA_W];

  sma_v2_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_MAX)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (s0_valid_r),
    .i_waddr (s0_ptr_r),
    .i_wdata (s0_data_r),
    .i_re    (accept_s),
    .i_raddr (ptr_r),
    .o_rdata (rd_data_s)
  );

  // Select register: one stage of delay before it can trigger a restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_r <= {SEL_W{1'b0}};
    end else begin
      sel_r <= SEL_W'(clamp_sel(32'(i_window_sel), LOG2_MAX));
    end
  end

  // Control FSM, two-stage datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_RESTART;
      k_r        <= {SEL_W{1'b0}};
      ptr_r      <= {LOG2_MAX{1'b0}};
      fill_r     <= {CNT_W{1'b0}};
      sum_r      <= {SUM_W{1'b0}};
      s0_valid_r <= 1'b0;
      s0_full_r  <= 1'b0;
      s0_emit_r  <= 1'b0;
      s0_data_r  <= {DATA_W{1'b0}};
      s0_ptr_r   <= {LOG2_MAX{1'b0}};
      s1_emit_r  <= 1'b0;
      o_valid_r  <= 1'b0;
      o_full_r   <= 1'b0;
      o_data_r   <= {DATA_W{1'b0}};
    end else if (restart_req_s) begin
      state_r    <= ST_RESTART;
      s0_valid_r <= 1'b0;
      s1_emit_r  <= 1'b0;
      o_valid_r  <= 1'b0;
      o_full_r   <= 1'b0;
    end else if (state_r == ST_RESTART) begin
      state_r    <= ST_FILL;
      k_r        <= sel_r;
      ptr_r      <= {LOG2_MAX{1'b0}};
      fill_r     <= {CNT_W{1'b0}};
      sum_r      <= {SUM_W{1'b0}};
      s0_valid_r <= 1'b0;
      s1_emit_r  <= 1'b0;
      o_valid_r  <= 1'b0;
      o_full_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        s0_valid_r <= 1'b1;
        s0_data_r  <= i_data;
        s0_ptr_r   <= ptr_r;
        s0_full_r  <= (eff_s >= n_s);
        s0_emit_r  <= (eff_s >= n_m1_s);
        ptr_r      <= ptr_next_s;
      end else begin
        s0_valid_r <= 1'b0;
      end

      if (s0_valid_r) begin
        sum_r     <= sum_next_s;
        fill_r    <= fill_inc_s;
        s1_emit_r <= s0_emit_r;
        if (fill_inc_s == n_s) begin
          state_r  <= ST_RUN;
          o_full_r <= 1'b1;
        end else begin
          state_r  <= state_r;
          o_full_r <= o_full_r;
        end
      end else begin
        s1_emit_r <= 1'b0;
      end

      o_valid_r <= s1_emit_r;
      if (s1_emit_r) begin
        o_data_r <= shifted_s[DATA_W-1:0];
      end else begin
        o_data_r <= o_data_r;
      end
    end
  end

  assign o_valid = o_valid_r;
  assign o_data  = o_data_r;
  assign o_full  = o_full_r;

endmodule
